instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, program buffer entries (power of two, at least 2).
REQ-002 The block SHALL have parameter IW, default 13, instruction width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port prog_valid, input, 1, program-load word valid.
REQ-006 The block SHALL have port prog_ready, output, 1, sequencer can accept a program word.
REQ-007 The block SHALL have port prog_instr, input, IW, program word.
REQ-008 The block SHALL have port prog_last, input, 1, marks the final word of a program.
REQ-009 The block SHALL have port start, input, 1, single-cycle request to execute the loaded program.
REQ-010 The block SHALL have port stall, input, 1, freezes issue while high.
REQ-011 The block SHALL have port instruction, output, IW, instruction to the processor.
REQ-012 The block SHALL have port instr_valid, output, 1, instruction is to be executed this cycle.
REQ-013 The block SHALL have port pc, output, log2(DEPTH), index of the entry currently presented.
REQ-014 The block SHALL have port prog_len, output, log2(DEPTH)+1, number of stored words.
REQ-015 The block SHALL have port busy, output, 1, high in LOAD or RUN.
REQ-016 The block SHALL have port done, output, 1, one-cycle pulse after the last instruction issues.

Function
REQ-017 The FSM SHALL have states IDLE (no program), LOAD, READY (program held), RUN and DONE.
REQ-018 A load word SHALL be accepted on a cycle with prog_valid && prog_ready.
- prog_ready is high in IDLE, LOAD and READY; low in RUN and DONE.
REQ-019 Loading SHALL be entered from IDLE or READY by an accepted word.
- That word is written to entry 0, prog_len becomes 1, and the state becomes LOAD, or READY if prog_last is set.
- Loading from READY discards the old program.
REQ-020 In LOAD, each accepted word SHALL be written to entry prog_len and prog_len SHALL increment.
- The state becomes READY when the accepted word has prog_last set, or when it fills entry DEPTH-1 (prog_len reaches DEPTH).
- Both cases are final with no error; words beyond DEPTH are never accepted in LOAD.
REQ-021 start SHALL be honoured only in READY with no accepted load word that cycle.
- It sets pc=0 and moves to RUN.
- start in IDLE, LOAD, RUN or DONE is ignored.
- A start in the same cycle as an accepted load word in READY is ignored; the load wins.
REQ-022 In RUN, instruction SHALL equal entry[pc] combinationally and instr_valid SHALL equal !stall.
REQ-023 In RUN with stall low, pc SHALL increment each cycle.
- When pc = prog_len-1 issues, the next state is DONE and pc holds.
REQ-024 In RUN with stall high, pc and state SHALL hold; the same instruction is re-presented and issues when stall falls.
REQ-025 DONE SHALL last exactly one cycle, with done=1 and instr_valid=0, then go to READY with the program retained.
REQ-026 instr_valid SHALL be 0 in every state except RUN.
- instruction outside RUN is entry[pc] and carries no meaning.
REQ-027 A program of length 1 SHALL issue in the first RUN cycle and reach DONE the following cycle.
REQ-028 Total latency from the start cycle to the done pulse, with no stall, SHALL be prog_len+1 cycles.

Reset
REQ-029 While rst is high, the state SHALL become IDLE on the clock edge, with pc=0, prog_len=0, done=0, instr_valid=0, busy=0 and prog_ready=1.
REQ-030 Reset SHALL dominate all other inputs in the same cycle, including mid-LOAD and mid-RUN.
- Buffer contents need not be cleared, but are unreachable until reloaded.
REQ-031 After reset deasserts, start SHALL be ignored until a program has been loaded.

Verification
REQ-032 Load 4 words 0x0001, 0x0801, 0x1000, 0x1800 (last on the 4th), then start -> instr_valid high for 4 cycles with those values in order, pc 0..3, then done pulse, state READY, prog_len=4.
REQ-033 Load 16 words without prog_last -> prog_ready drops after the 16th, prog_len=16, a 17th word is not accepted, and a run issues all 16 words.
REQ-034 During a run of 3 words, assert stall for 2 cycles at pc=1 -> instruction stays at word 1 with instr_valid=0, resumes, and done arrives 2 cycles later than the unstalled case.
REQ-035 Assert rst at pc=2 of a 5-word run -> next cycle IDLE, instr_valid=0, prog_len=0; a following start is ignored.
REQ-036 In READY, drive start together with an accepted word, prog_last=1 -> no run; prog_len=1; a later start issues only that word and then pulses done.
REQ-037 Run the same 2-word program twice with back-to-back starts after READY -> identical issue sequences; start pulses during RUN/DONE have no effect.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: loads a program of up to DEPTH words into a local
// buffer, then issues it in order to a processor on request. Issue can be
// held by a stall input. A one-cycle done pulse follows the final issue, and
// the program stays in the buffer so it can be run again.
module instruction_sequencer #(
  parameter int DEPTH = 16,
  parameter int IW    = 13,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_valid,
  output logic          prog_ready,
  input  logic [IW-1:0] prog_instr,
  input  logic          prog_last,
  input  logic          start,
  input  logic          stall,
  output logic [IW-1:0] instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic [AW:0]   prog_len,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    r_state;
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_len;
  logic [IW-1:0] r_mem [DEPTH];

  logic          w_accept;
  logic [AW-1:0] w_waddr;
  logic [AW:0]   w_len_inc;
  logic          w_last_issue;

  // A word is taken whenever the source offers one and we are not executing.
  assign prog_ready = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_READY);
  assign w_accept   = prog_valid && prog_ready;

  // A new program always starts at entry 0; only LOAD appends after prog_len.
  assign w_waddr      = (r_state == S_LOAD) ? r_len[AW-1:0] : '0;
  assign w_len_inc    = r_len + (AW+1)'(1);
  assign w_last_issue = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));

  assign instruction = r_mem[r_pc];
  assign instr_valid = (r_state == S_RUN) && !stall;
  assign pc          = r_pc;
  assign prog_len    = r_len;
  assign busy        = (r_state == S_LOAD) || (r_state == S_RUN);
  assign done        = (r_state == S_DONE);

  // Program buffer write port.
  // NOTE: the buffer has no reset on purpose; it is only read below prog_len,
  // which reset clears, so stale contents can never be issued.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_mem[w_waddr] <= prog_instr;
    end
  end

  // Control FSM: load bookkeeping, start handling and program counter.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_READY: begin
          if (w_accept) begin
            // A new first word discards any program already held.
            r_len   <= (AW+1)'(1);
            r_state <= prog_last ? S_READY : S_LOAD;
          end else if ((r_state == S_READY) && start) begin
            r_pc    <= '0;
            r_state <= S_RUN;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_len <= w_len_inc;
            // Filling the last entry ends the load just like prog_last.
            if (prog_last || (w_len_inc == (AW+1)'(DEPTH))) begin
              r_state <= S_READY;
            end
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (w_last_issue) begin
              r_state <= S_DONE;
            end else begin
              r_pc <= r_pc + AW'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_READY;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomised scoreboard bench for instruction_sequencer. Stimulus tasks load
// programs into a reference copy and queue the issue sequence each run must
// produce; a monitor pops that queue whenever the DUT issues or pulses done.
module tb_instruction_sequencer;

  localparam int DEPTH = 16;
  localparam int IW    = 13;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    bit            is_done;
    logic [IW-1:0] instr;
    int            pc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          prog_valid;
  logic          prog_ready;
  logic [IW-1:0] prog_instr;
  logic          prog_last;
  logic          start;
  logic          stall;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic [AW:0]   prog_len;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  exp_t          exp_q[$];
  logic [IW-1:0] m_prog[$];
  logic [IW-1:0] m_stage[$];

  instruction_sequencer #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_valid  (prog_valid),
    .prog_ready  (prog_ready),
    .prog_instr  (prog_instr),
    .prog_last   (prog_last),
    .start       (start),
    .stall       (stall),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .prog_len    (prog_len),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every issue and every done pulse must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (instr_valid === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].is_done) begin
        check("unexpected_issue", {31'd0, instr_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("issue_instr", instruction, e.instr);
        check("issue_pc", pc, e.pc);
      end
    end
    if (done === 1'b1) begin
      check("done_expected", (exp_q.size() > 0 && exp_q[0].is_done) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0 && exp_q[0].is_done) void'(exp_q.pop_front());
    end
  end

  // Present m_stage as one program; the model copy becomes that program.
  task automatic load_words(input bit use_last);
    int n;
    n = m_stage.size();
    m_prog.delete();
    for (int i = 0; i < n; i++) begin
      prog_valid = 1'b1;
      prog_instr = m_stage[i];
      prog_last  = use_last && (i == n - 1);
      check("load_ready", prog_ready, 1);
      m_prog.push_back(m_stage[i]);
      tick();
    end
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    check("load_len", prog_len, n);
    check("load_busy", busy, 0);
  endtask

  task automatic load_random(input int n, input bit use_last);
    m_stage.delete();
    for (int i = 0; i < n; i++) m_stage.push_back(IW'($urandom));
    load_words(use_last);
  endtask

  // mode 0: no stall; 1: random stalls and start noise; 2: 2-cycle stall at pc=1.
  task automatic run_prog(input int mode);
    int c, issued, nst, len, exp_c;
    len = m_prog.size();
    for (int i = 0; i < len; i++) exp_q.push_back('{1'b0, m_prog[i], i});
    exp_q.push_back('{1'b1, '0, 0});
    start = 1'b1;
    tick();
    start  = 1'b0;
    c      = 1;
    issued = 0;
    nst    = 0;
    while (done !== 1'b1 && c < 200) begin
      stall = (mode == 1) ? ($urandom_range(0, 3) == 0) : (mode == 2 && issued == 1 && nst < 2);
      if (mode == 1) start = 1'($urandom_range(0, 1));
      #1;
      if (stall) begin
        nst++;
        check("stall_valid", instr_valid, 0);
        check("stall_instr", instruction, m_prog[issued]);
        check("stall_pc", pc, issued);
      end
      tick();
      if (!stall) issued++;
      c++;
    end
    stall = 1'b0;
    exp_c = (mode == 2) ? len + 3 : len + 1 + nst;
    check("run_latency", c, exp_c);
    // A start during the done cycle must not relaunch the program.
    start = 1'b1;
    check("done_valid", instr_valid, 0);
    tick();
    start = 1'b0;
    check("after_done_busy", busy, 0);
    check("after_done_ready", prog_ready, 1);
    check("after_done_len", prog_len, len);
  endtask

  initial begin
    logic [IW-1:0] w;
    rst        = 1'b1;
    prog_valid = 1'b0;
    prog_instr = '0;
    prog_last  = 1'b0;
    start      = 1'b0;
    stall      = 1'b0;
    repeat (3) tick();
    check("rst_len", prog_len, 0);
    check("rst_pc", pc, 0);
    check("rst_done", done, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", prog_ready, 1);
    rst = 1'b0;

    // start with nothing loaded is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_start_busy", busy, 0);
    tick();
    check("idle_start_len", prog_len, 0);

    // fixed four-word program
    m_stage = '{13'h0001, 13'h0801, 13'h1000, 13'h1800};
    load_words(1'b1);
    run_prog(0);

    // full buffer without prog_last ends the load on its own
    load_random(DEPTH, 1'b0);
    check("full_len", prog_len, DEPTH);
    run_prog(0);

    // two-cycle stall at pc=1
    load_random(3, 1'b1);
    run_prog(2);

    // reset in the middle of a five-word run, at pc=2
    load_random(5, 1'b1);
    for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, m_prog[i], i});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_run_pc", pc, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_prog.delete();
    check("mrst_len", prog_len, 0);
    check("mrst_valid", instr_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_pc", pc, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mrst_start_busy", busy, 0);
    tick();
    check("mrst_start_valid", instr_valid, 0);

    // load word and start together in READY: load wins
    load_random(2, 1'b1);
    w          = IW'($urandom);
    prog_valid = 1'b1;
    prog_instr = w;
    prog_last  = 1'b1;
    start      = 1'b1;
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    start      = 1'b0;
    m_prog.delete();
    m_prog.push_back(w);
    check("ld_start_len", prog_len, 1);
    check("ld_start_busy", busy, 0);
    tick();
    check("ld_start_valid", instr_valid, 0);
    run_prog(0);

    // same two-word program twice, with start noise during RUN and DONE
    load_random(2, 1'b1);
    run_prog(1);
    run_prog(1);

    // random programs with random stalls
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      load_random(n, (n == DEPTH) ? 1'($urandom_range(0, 1)) : 1'b1);
      run_prog(1);
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
